reg_access_ctrl: RTL and testbench

Initiator for the 16-bit load/hold register: it accepts read and write commands over a valid/ready command channel, drives the register's data and load-enable inputs, and samples its read port. It returns one response per command over a valid/ready response channel. It sits between upstream control logic and the register, which holds its value when the load-enable is low.

---
 rtl/reg_access_pkg.sv | 19 +
 rtl/reg_access_ctrl.sv | 103 ++++++++++
 tb/tb_reg_access_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_pkg.sv
// Shared types and constants for the register access controller.
// The CHECK state is only reachable when REG_ACCESS_READBACK_EN is defined.
package reg_access_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CHECK,
    RESP
  } state_t;

endpackage

// File: rtl/reg_access_ctrl.sv
// Single-outstanding read/write initiator for a load/hold register.
// Define REG_ACCESS_READBACK_EN to verify every write by reading the register back.
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] reg_write_port,
  output logic             reg_choice,
  input  logic [WIDTH-1:0] reg_read_port,
  output logic [CNT_W-1:0] txn_count
);

  state_t state;

  // rsp_data doubles as the latched write data, so CHECK compares against it directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      reg_write_port <= '0;
      reg_choice     <= 1'b0;
      txn_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          reg_choice <= 1'b0;
          rsp_valid  <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write == CMD_WRITE) begin
              state          <= WRITE;
              reg_choice     <= 1'b1;
              reg_write_port <= cmd_data;
              rsp_data       <= cmd_data;
              rsp_err        <= 1'b0;
            end else begin
              state <= READ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        WRITE: begin
          reg_choice <= 1'b0;
`ifdef REG_ACCESS_READBACK_EN
          state      <= CHECK;
`else
          state      <= RESP;
          rsp_valid  <= 1'b1;
`endif
        end

`ifdef REG_ACCESS_READBACK_EN
        CHECK: begin
          rsp_err   <= (reg_read_port != rsp_data);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
`endif

        READ: begin
          rsp_data  <= reg_read_port;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_count <= txn_count + CNT_W'(1);
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          cmd_ready  <= 1'b0;
          rsp_valid  <= 1'b0;
          reg_choice <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl with a behavioural load/hold register.
// Readback checks are enabled when REG_ACCESS_READBACK_EN is defined.
module tb_reg_access_ctrl;
  import reg_access_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
`ifdef REG_ACCESS_READBACK_EN
  localparam bit READBACK = 1'b1;
  localparam int WLAT     = 2;
`else
  localparam bit READBACK = 1'b0;
  localparam int WLAT     = 1;
`endif

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  logic             clk        = 1'b0;
  logic             reset      = 1'b0;
  logic             cmd_valid  = 1'b0;
  logic             cmd_write  = 1'b0;
  logic [WIDTH-1:0] cmd_data   = '0;
  logic             rsp_ready  = 1'b0;
  logic             force_zero = 1'b0;
  logic             cmd_ready;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [WIDTH-1:0] reg_write_port;
  logic             reg_choice;
  logic [WIDTH-1:0] reg_read_port;
  logic [CNT_W-1:0] txn_count;
  logic [WIDTH-1:0] reg_q;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] model_reg  = '0;
  int               exp_count  = 0;
  int               ready_mode = 1;
  int               n_checks   = 0;
  int               n_pass     = 0;

  always #5 clk = ~clk;

  reg_access_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .reg_write_port(reg_write_port), .reg_choice(reg_choice), .reg_read_port(reg_read_port),
    .txn_count(txn_count)
  );

  // Stand-in for the existing load/hold register; force_zero models a stuck read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) reg_q <= '0;
    else if (reg_choice) reg_q <= reg_write_port;
  end
  assign reg_read_port = force_zero ? '0 : reg_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ready_mode: 0 = stall, 1 = always ready, 2 = random backpressure.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 32'(1), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_cmd(input logic wr, input logic [WIDTH-1:0] data, input bit expect_rsp);
    exp_t e;
    int n = 0;
    cmd_write = wr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'(0), 32'(1));
      cmd_valid = 1'b0;
      return;
    end
    if (wr) begin
      e.data    = data;
      e.err     = READBACK && force_zero && (data != '0);
      model_reg = data;
    end else begin
      e.data = model_reg;
      e.err  = 1'b0;
    end
    if (expect_rsp) begin
      sb_q.push_back(e);
      exp_count++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = WIDTH'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || !cmd_ready) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      check({name, "_timeout"}, 32'(0), 32'(1));
      sb_q.delete();
    end
    check({name, "_txn_count"}, 32'(txn_count), 32'(exp_count % (1 << CNT_W)));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [WIDTH-1:0] d;
    logic             w;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rsp_err", 32'(rsp_err), 32'(0));
    check("rst_reg_write_port", 32'(reg_write_port), 32'(0));
    check("rst_reg_choice", 32'(reg_choice), 32'(0));
    check("rst_txn_count", 32'(txn_count), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_cmd_ready_low", 32'(cmd_ready), 32'(0));
    @(posedge clk);
    #1;
    check("release_cmd_ready_high", 32'(cmd_ready), 32'(1));

    send_cmd(CMD_WRITE, 16'd65, 1'b1);
    check("wr_reg_choice_on", 32'(reg_choice), 32'(1));
    check("wr_reg_write_port", 32'(reg_write_port), 32'(65));
    check("wr_cmd_ready_low", 32'(cmd_ready), 32'(0));
    @(posedge clk);
    #1;
    check("wr_reg_choice_off", 32'(reg_choice), 32'(0));
    check("wr_rsp_latency", 32'(rsp_valid), 32'(WLAT == 1));
    wait_idle("write65");
    send_cmd(CMD_READ, 16'd0, 1'b1);
    @(posedge clk);
    #1;
    check("rd_rsp_latency", 32'(rsp_valid), 32'(1));
    wait_idle("read65");

    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_cmd(CMD_WRITE, 16'd241, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = CMD_READ;
    repeat (WLAT) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'(1));
      check("stall_rsp_data", 32'(rsp_data), 32'(241));
      check("stall_cmd_ready", 32'(cmd_ready), 32'(0));
      @(posedge clk);
      #1;
    end
    cmd_valid  = 1'b0;
    ready_mode = 1;
    wait_idle("stall");

    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      d = WIDTH'($urandom);
      send_cmd(w, d, 1'b1);
    end
    ready_mode = 1;
    wait_idle("random");

    send_cmd(CMD_WRITE, 16'd73, 1'b0);
    check("abort_reg_choice_on", 32'(reg_choice), 32'(1));
    reset = 1'b0;
    #1;
    check("abort_reg_choice_off", 32'(reg_choice), 32'(0));
    check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
    check("abort_cmd_ready", 32'(cmd_ready), 32'(0));
    exp_count = 0;
    model_reg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(rsp_valid), 32'(0));
    check("abort_txn_count", 32'(txn_count), 32'(0));
    check("abort_cmd_ready_back", 32'(cmd_ready), 32'(1));

`ifdef REG_ACCESS_READBACK_EN
    force_zero = 1'b1;
    send_cmd(CMD_WRITE, 16'd256, 1'b1);
    wait_idle("readback_err");
    force_zero = 1'b0;
`endif

    send_cmd(CMD_WRITE, 16'd198, 1'b1);
    wait_idle("write198");
    for (int i = 0; i < 256; i++) begin
      send_cmd(CMD_READ, WIDTH'($urandom), 1'b1);
      wait_idle("wrap_read");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
